// File: rtl/tlb_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tlb_ctrl_pkg
// Shared types for the joint-TLB controller: the TLB instruction encoding,
// the layout of one TLB entry as seen by every lookup instance, and the
// controller's FSM state encoding.
// -----------------------------------------------------------------------------
package tlb_ctrl_pkg;

  typedef enum logic [1:0] {
    TLB_OP_TLBP  = 2'd0,
    TLB_OP_TLBR  = 2'd1,
    TLB_OP_TLBWI = 2'd2,
    TLB_OP_TLBWR = 2'd3
  } tlb_op_t;

  // One joint-TLB entry: a VPN2 pair mapping onto an even/odd PFN pair.
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic [11:0] mask;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } tlb_state_t;

  function automatic logic is_write_op(tlb_op_t op);
    return (op == TLB_OP_TLBWI) || (op == TLB_OP_TLBWR);
  endfunction

endpackage

// File: rtl/tlb_ctrl_probe.sv
// -----------------------------------------------------------------------------
// tlb_ctrl_probe
// Combinational TLBP matcher. Compares a VPN2/ASID pair against every entry
// and returns the lowest matching index, or miss=1 with index=0.
//   entries : TLB contents
//   vpn2    : virtual page pair number being probed
//   asid    : address-space id being probed
//   miss    : no entry matched
//   index   : lowest matching entry (0 on miss)
// -----------------------------------------------------------------------------
module tlb_ctrl_probe
  import tlb_ctrl_pkg::*;
#(
  parameter int N_TLB_ENTRIES = 32,
  localparam int IW = $clog2(N_TLB_ENTRIES)
) (
  input  tlb_entry_t [N_TLB_ENTRIES-1:0] entries,
  input  logic [18:0]                    vpn2,
  input  logic [7:0]                     asid,
  output logic                           miss,
  output logic [IW-1:0]                  index
);

  logic [18:0] cmp_mask;
  logic        unused_payload;

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    miss     = 1'b1;
    index    = '0;
    cmp_mask = '0;
    for (int i = N_TLB_ENTRIES - 1; i >= 0; i--) begin
      cmp_mask = ~{7'b0, entries[i].mask};
      if (((entries[i].vpn2 & cmp_mask) == (vpn2 & cmp_mask)) &&
          (entries[i].g || (entries[i].asid == asid))) begin
        miss  = 1'b0;
        index = IW'(i);
      end
    end
  end

  // Translation payload is not part of the match.
  always_comb begin
    unused_payload = 1'b0;
    for (int i = 0; i < N_TLB_ENTRIES; i++) begin
      unused_payload = unused_payload ^
        (^{entries[i].pfn0, entries[i].c0, entries[i].d0, entries[i].v0,
           entries[i].pfn1, entries[i].c1, entries[i].d1, entries[i].v1});
    end
  end

endmodule

// File: rtl/tlb_ctrl.sv
// -----------------------------------------------------------------------------
// tlb_ctrl
// Sequencer and owner of the MMU joint-TLB storage. Executes TLBP/TLBR/TLBWI/
// TLBWR as IDLE -> EXEC -> DONE, maintains the Random register and drives the
// entries array used by all lookup paths.
//   clk, rst           : clock, asynchronous active-low reset
//   op_valid/op        : instruction request; op_ready high in IDLE
//   done               : one-cycle pulse when results are valid
//   cp0_*              : CP0 operands, sampled at accept
//   cp0_wired/wired_we : Wired value and its write strobe
//   entries            : current TLB contents
//   rd_entry           : TLBR result
//   probe_index/miss   : TLBP result
//   random             : Random register
//   tlb_update         : pulse with done after a write (micro-TLB flush)
// -----------------------------------------------------------------------------
module tlb_ctrl
  import tlb_ctrl_pkg::*;
#(
  parameter int N_TLB_ENTRIES = 32,
  localparam int IW = $clog2(N_TLB_ENTRIES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           op_valid,
  input  tlb_op_t                        op,
  output logic                           op_ready,
  output logic                           done,
  input  logic [31:0]                    cp0_entryhi,
  input  logic [31:0]                    cp0_entrylo0,
  input  logic [31:0]                    cp0_entrylo1,
  input  logic [31:0]                    cp0_pagemask,
  input  logic [IW-1:0]                  cp0_index,
  input  logic [IW-1:0]                  cp0_wired,
  input  logic                           wired_we,
  output tlb_entry_t [N_TLB_ENTRIES-1:0] entries,
  output tlb_entry_t                     rd_entry,
  output logic [IW-1:0]                  probe_index,
  output logic                           probe_miss,
  output logic [IW-1:0]                  random,
  output logic                           tlb_update
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N_TLB_ENTRIES - 1);

  tlb_state_t                     state_q, state_d;
  logic                           accept;
  tlb_entry_t                     new_entry;
  logic                           unused_cp0_bits;

  tlb_op_t                        op_p0;
  logic [IW-1:0]                  idx_p0;
  tlb_entry_t                     entry_p0;

  tlb_entry_t [N_TLB_ENTRIES-1:0] entries_q;
  tlb_entry_t                     rd_entry_q;
  logic [IW-1:0]                  probe_index_q;
  logic                           probe_miss_q;
  logic [IW-1:0]                  random_q, random_d;

  logic                           hit_miss;
  logic [IW-1:0]                  hit_index;

  assign accept = (state_q == ST_IDLE) && op_valid;

  // Entry image built from the CP0 registers; its vpn2/asid double as the
  // TLBP search key.
  always_comb begin
    new_entry      = '0;
    new_entry.vpn2 = cp0_entryhi[31:13];
    new_entry.asid = cp0_entryhi[7:0];
    new_entry.mask = cp0_pagemask[24:13];
    new_entry.g    = cp0_entrylo0[0] & cp0_entrylo1[0];
    new_entry.pfn0 = cp0_entrylo0[25:6];
    new_entry.c0   = cp0_entrylo0[5:3];
    new_entry.d0   = cp0_entrylo0[2];
    new_entry.v0   = cp0_entrylo0[1];
    new_entry.pfn1 = cp0_entrylo1[25:6];
    new_entry.c1   = cp0_entrylo1[5:3];
    new_entry.d1   = cp0_entrylo1[2];
    new_entry.v1   = cp0_entrylo1[1];
  end

  assign unused_cp0_bits = ^{cp0_entryhi[12:8], cp0_entrylo0[31:26],
                             cp0_entrylo1[31:26], cp0_pagemask[31:25],
                             cp0_pagemask[12:0]};

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (op_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    op_ready   = (state_q == ST_IDLE);
    done       = (state_q == ST_DONE);
    tlb_update = (state_q == ST_DONE) && is_write_op(op_p0);
  end

  // ---- accept stage: capture request ----
  // TLBWR takes Random as it stands before this edge's update, so a
  // concurrent wired_we cannot redirect the write.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0    <= op;
      idx_p0   <= (op == TLB_OP_TLBWR) ? random_q : cp0_index;
      entry_p0 <= new_entry;
    end
  end

  tlb_ctrl_probe #(.N_TLB_ENTRIES(N_TLB_ENTRIES)) u_probe (
    .entries (entries_q),
    .vpn2    (entry_p0.vpn2),
    .asid    (entry_p0.asid),
    .miss    (hit_miss),
    .index   (hit_index)
  );

  // ---- execute stage: write storage / register results ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entries_q <= '0;
    end else if ((state_q == ST_EXEC) && is_write_op(op_p0)) begin
      entries_q[idx_p0] <= entry_p0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_entry_q    <= '0;
      probe_index_q <= '0;
      probe_miss_q  <= 1'b1;
    end else if (state_q == ST_EXEC) begin
      if (op_p0 == TLB_OP_TLBR) rd_entry_q <= entries_q[idx_p0];
      if (op_p0 == TLB_OP_TLBP) begin
        probe_index_q <= hit_index;
        probe_miss_q  <= hit_miss;
      end
    end
  end

  // Random wraps to the top when it reaches Wired or zero; with Wired at
  // the top index it therefore sits there permanently.
  always_comb begin
    if (wired_we)                                  random_d = LAST_IDX;
    else if ((random_q == cp0_wired) || (random_q == '0)) random_d = LAST_IDX;
    else                                           random_d = random_q - IW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) random_q <= LAST_IDX;
    else      random_q <= random_d;
  end

  assign entries     = entries_q;
  assign rd_entry    = rd_entry_q;
  assign probe_index = probe_index_q;
  assign probe_miss  = probe_miss_q;
  assign random      = random_q;

endmodule

// File: tb/tb_tlb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tlb_ctrl
// Self-checking bench for tlb_ctrl with a behavioural model of the TLB
// contents, probe results and the Random register.
// -----------------------------------------------------------------------------
module tb_tlb_ctrl;
  import tlb_ctrl_pkg::*;

  logic             clk;
  logic             rst;
  logic             op_valid;
  tlb_op_t          op;
  logic             op_ready;
  logic             done;
  logic [31:0]      cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_pagemask;
  logic [4:0]       cp0_index, cp0_wired;
  logic             wired_we;
  tlb_entry_t [31:0] entries;
  tlb_entry_t       rd_entry;
  logic [4:0]       probe_index;
  logic             probe_miss;
  logic [4:0]       random;
  logic             tlb_update;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  tlb_entry_t [31:0] m_ent;
  tlb_entry_t        m_rd;
  logic [4:0]        m_pidx;
  bit                m_pmiss;
  int                m_random;

  tlb_ctrl #(.N_TLB_ENTRIES(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_ready(op_ready),
    .done(done), .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0),
    .cp0_entrylo1(cp0_entrylo1), .cp0_pagemask(cp0_pagemask),
    .cp0_index(cp0_index), .cp0_wired(cp0_wired), .wired_we(wired_we),
    .entries(entries), .rd_entry(rd_entry), .probe_index(probe_index),
    .probe_miss(probe_miss), .random(random), .tlb_update(tlb_update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Random register reference: integer countdown with reload to 31.
  always @(posedge clk or negedge rst) begin
    if (!rst)                                    m_random <= 31;
    else if (wired_we)                           m_random <= 31;
    else if (m_random == int'(cp0_wired) || m_random == 0) m_random <= 31;
    else                                         m_random <= m_random - 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic tlb_entry_t model_entry(input logic [31:0] ehi, lo0, lo1, pm);
    tlb_entry_t e;
    e.vpn2 = 19'(ehi / 8192);
    e.asid = 8'(ehi % 256);
    e.mask = 12'((pm / 8192) % 4096);
    e.g    = (lo0 % 2 == 1) && (lo1 % 2 == 1);
    e.pfn0 = 20'((lo0 / 64) % (1 << 20));
    e.c0   = 3'((lo0 / 8) % 8);
    e.d0   = ((lo0 / 4) % 2) == 1;
    e.v0   = ((lo0 / 2) % 2) == 1;
    e.pfn1 = 20'((lo1 / 64) % (1 << 20));
    e.c1   = 3'((lo1 / 8) % 8);
    e.d1   = ((lo1 / 4) % 2) == 1;
    e.v1   = ((lo1 / 2) % 2) == 1;
    return e;
  endfunction

  // First hit in ascending order wins.
  task automatic model_probe(input logic [31:0] ehi);
    int vpn2, asid, msk;
    vpn2 = int'(ehi / 8192);
    asid = int'(ehi % 256);
    m_pmiss = 1'b1;
    m_pidx  = '0;
    for (int i = 0; i < 32; i++) begin
      msk = int'(m_ent[i].mask);
      if (m_pmiss && ((int'(m_ent[i].vpn2) & ~msk) == (vpn2 & ~msk)) &&
          (m_ent[i].g || int'(m_ent[i].asid) == asid)) begin
        m_pmiss = 1'b0;
        m_pidx  = 5'(i);
      end
    end
  endtask

  task automatic reset_model();
    m_ent   = '0;
    m_rd    = '0;
    m_pidx  = '0;
    m_pmiss = 1'b1;
  endtask

  // Issue one op from IDLE and check EXEC, DONE and the return to IDLE.
  task automatic do_op(input tlb_op_t o, input logic [31:0] ehi, lo0, lo1, pm,
                       input logic [4:0] idx, input bit we_acc, input bit we_exec,
                       input string tag);
    logic [4:0] widx;
    bit         wr;
    int         bad;
    wr = (o == TLB_OP_TLBWI) || (o == TLB_OP_TLBWR);
    n_checks++;
    if (op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s op_ready_idle: got %0b want 1", tag, op_ready);
    end
    op_valid = 1'b1; op = o;
    cp0_entryhi = ehi; cp0_entrylo0 = lo0; cp0_entrylo1 = lo1;
    cp0_pagemask = pm; cp0_index = idx; wired_we = we_acc;
    widx = (o == TLB_OP_TLBWR) ? 5'(m_random) : idx;
    step();
    // EXEC: scramble operands to prove they were captured at accept
    op_valid = 1'b0; wired_we = we_exec;
    cp0_entryhi = $urandom; cp0_entrylo0 = $urandom; cp0_entrylo1 = $urandom;
    cp0_index = 5'($urandom);
    n_checks++;
    if (op_ready !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s exec_ctrl: got ready=%0b done=%0b want 0 0", tag, op_ready, done);
    end
    step();
    wired_we = 1'b0;
    if (wr) m_ent[widx] = model_entry(ehi, lo0, lo1, pm);
    if (o == TLB_OP_TLBR) m_rd = m_ent[idx];
    if (o == TLB_OP_TLBP) model_probe(ehi);
    n_checks++;
    if (done !== 1'b1 || tlb_update !== wr) begin
      n_fail++;
      $display("FAIL %s done_pulse: got done=%0b upd=%0b want 1 %0b", tag, done, tlb_update, wr);
    end
    n_checks++;
    if (entries !== m_ent) begin
      n_fail++;
      bad = 0;
      for (int i = 31; i >= 0; i--) if (entries[i] !== m_ent[i]) bad = i;
      $display("FAIL %s entries[%0d]: got %h want %h", tag, bad, entries[bad], m_ent[bad]);
    end
    n_checks++;
    if (rd_entry !== m_rd) begin
      n_fail++;
      $display("FAIL %s rd_entry: got %h want %h", tag, rd_entry, m_rd);
    end
    n_checks++;
    if (probe_miss !== m_pmiss || probe_index !== m_pidx) begin
      n_fail++;
      $display("FAIL %s probe: got miss=%0b idx=%0d want miss=%0b idx=%0d",
               tag, probe_miss, probe_index, m_pmiss, m_pidx);
    end
    n_checks++;
    if (int'(random) !== m_random) begin
      n_fail++;
      $display("FAIL %s random: got %0d want %0d", tag, random, m_random);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || tlb_update !== 1'b0 || op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s back_idle: got done=%0b upd=%0b ready=%0b want 0 0 1",
               tag, done, tlb_update, op_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; op_valid = 1'b0; op = TLB_OP_TLBP; wired_we = 1'b0;
    cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0; cp0_pagemask = '0;
    cp0_index = '0; cp0_wired = '0;
    reset_model();
    step(); step();
    n_checks++;
    if (op_ready !== 1'b1 || done !== 1'b0 || tlb_update !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready=%0b done=%0b upd=%0b want 1 0 0", op_ready, done, tlb_update);
    end
    n_checks++;
    if (random !== 5'd31) begin
      n_fail++;
      $display("FAIL reset_random: got %0d want 31", random);
    end
    n_checks++;
    if (entries !== '0 || rd_entry !== '0) begin
      n_fail++;
      $display("FAIL reset_storage: entries or rd_entry nonzero");
    end
    n_checks++;
    if (probe_miss !== 1'b1 || probe_index !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_probe: got miss=%0b idx=%0d want 1 0", probe_miss, probe_index);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (random !== 5'd26) begin
      n_fail++;
      $display("FAIL idle_countdown: got %0d want 26", random);
    end
  endtask

  task automatic test_tlbwi();
    do_op(TLB_OP_TLBWI, 32'h0040_2011, 32'h0000_1017, 32'h0000_1057, 32'h0,
          5'd5, 1'b0, 1'b0, "tlbwi");
    n_checks++;
    if (entries[5].vpn2 !== 19'h00201 || entries[5].asid !== 8'h11 ||
        entries[5].g !== 1'b1 || entries[5].pfn0 !== 20'h40) begin
      n_fail++;
      $display("FAIL tlbwi_fields: got vpn2=%h asid=%h g=%0b pfn0=%h want 00201 11 1 00040",
               entries[5].vpn2, entries[5].asid, entries[5].g, entries[5].pfn0);
    end
  endtask

  task automatic test_tlbp();
    do_op(TLB_OP_TLBP, 32'h0040_2022, '0, '0, '0, 5'd0, 1'b0, 1'b0, "tlbp_hit");
    n_checks++;
    if (probe_miss !== 1'b0 || probe_index !== 5'd5) begin
      n_fail++;
      $display("FAIL tlbp_hit_const: got miss=%0b idx=%0d want 0 5", probe_miss, probe_index);
    end
    do_op(TLB_OP_TLBP, 32'h0080_0022, '0, '0, '0, 5'd0, 1'b0, 1'b0, "tlbp_miss");
    n_checks++;
    if (probe_miss !== 1'b1 || probe_index !== 5'd0) begin
      n_fail++;
      $display("FAIL tlbp_miss_const: got miss=%0b idx=%0d want 1 0", probe_miss, probe_index);
    end
  endtask

  task automatic wait_random(input int target, input string tag);
    int k;
    k = 0;
    while (int'(random) != target && k < 40) begin
      step();
      k++;
    end
    n_checks++;
    if (int'(random) != target) begin
      n_fail++;
      $display("FAIL %s wait_random: got %0d want %0d within 40 cycles", tag, random, target);
    end
  endtask

  task automatic test_random_wired();
    cp0_wired = 5'd4;
    wait_random(4, "wired4");
    step();
    n_checks++;
    if (random !== 5'd31) begin
      n_fail++;
      $display("FAIL wired_reload: got %0d want 31", random);
    end
    wait_random(10, "wr_same_cycle");
    do_op(TLB_OP_TLBWR, 32'h1234_6033, 32'h0000_2a5e, 32'h0000_3f00, 32'h0,
          5'd0, 1'b1, 1'b0, "tlbwr_wired_we");
    n_checks++;
    if (entries[10].vpn2 !== 19'h091A3 || entries[10].asid !== 8'h33) begin
      n_fail++;
      $display("FAIL tlbwr_entry10: got vpn2=%h asid=%h want 091a3 33",
               entries[10].vpn2, entries[10].asid);
    end
    wait_random(20, "wr_exec_we");
    do_op(TLB_OP_TLBWR, 32'h0abc_e044, 32'h0000_0001, 32'h0000_0001, 32'h0,
          5'd0, 1'b0, 1'b1, "tlbwr_exec_we");
    n_checks++;
    if (entries[20].vpn2 !== 19'h055E7 || entries[20].g !== 1'b1) begin
      n_fail++;
      $display("FAIL tlbwr_entry20: got vpn2=%h g=%0b want 055e7 1",
               entries[20].vpn2, entries[20].g);
    end
    cp0_wired = 5'd0;
  endtask

  task automatic test_back_to_back();
    bit rdy_exp[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bit dn_exp[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    op_valid = 1'b1; op = TLB_OP_TLBR; cp0_index = 5'd5;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) cp0_index = 5'd10;
      n_checks++;
      if (op_ready !== rdy_exp[c] || done !== dn_exp[c]) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got ready=%0b done=%0b want %0b %0b",
                 c, op_ready, done, rdy_exp[c], dn_exp[c]);
      end
      if (c == 2) begin
        n_checks++;
        if (rd_entry !== m_ent[5]) begin
          n_fail++;
          $display("FAIL b2b_tlbr5: got %h want %h", rd_entry, m_ent[5]);
        end
      end
      step();
    end
    op_valid = 1'b0;
    m_rd = m_ent[10];
    n_checks++;
    if (rd_entry !== m_rd) begin
      n_fail++;
      $display("FAIL b2b_tlbr10: got %h want %h", rd_entry, m_rd);
    end
  endtask

  task automatic test_random_ops();
    tlb_op_t    o;
    logic [31:0] ehi, pm;
    int         k;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) cp0_wired = 5'($urandom_range(0, 31));
      o   = tlb_op_t'($urandom_range(0, 3));
      ehi = $urandom;
      if (o == TLB_OP_TLBP && $urandom_range(0, 1) == 1) begin
        k   = $urandom_range(0, 31);
        ehi = {m_ent[k].vpn2, 5'($urandom),
               ($urandom_range(0, 1) == 1) ? m_ent[k].asid : 8'($urandom)};
      end
      pm = ($urandom_range(0, 3) == 0) ? {7'b0, 12'($urandom), 13'b0} : 32'h0;
      do_op(o, ehi, $urandom, $urandom, pm, 5'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), "rand");
    end
    cp0_wired = 5'd0;
  endtask

  task automatic test_reset_mid();
    op_valid = 1'b1; op = TLB_OP_TLBWI; cp0_index = 5'd7;
    cp0_entryhi = 32'hdead_b0ef; cp0_entrylo0 = 32'h0000_ffff; cp0_entrylo1 = 32'h0000_ffff;
    cp0_pagemask = 32'h0;
    step();
    op_valid = 1'b0;
    rst = 1'b0;
    reset_model();
    #1;
    n_checks++;
    if (op_ready !== 1'b1 || done !== 1'b0 || entries !== '0 || random !== 5'd31) begin
      n_fail++;
      $display("FAIL midreset_abort: got ready=%0b done=%0b e7=%h rnd=%0d want 1 0 0 31",
               op_ready, done, entries[7], random);
    end
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if (done !== 1'b0 || tlb_update !== 1'b0 || entries[7] !== '0 || op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_after: got done=%0b upd=%0b e7=%h ready=%0b want 0 0 0 1",
               done, tlb_update, entries[7], op_ready);
    end
    do_op(TLB_OP_TLBR, '0, '0, '0, '0, 5'd7, 1'b0, 1'b0, "midreset_tlbr");
  endtask

  initial begin
    test_reset();
    test_tlbwi();
    test_tlbp();
    test_random_wired();
    test_back_to_back();
    test_random_ops();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tlb_ctrl.md
# tlb_ctrl

Sequencer and owner of the MMU's joint TLB storage. It accepts CP0 TLB instructions (TLBP, TLBR, TLBWI, TLBWR) over a valid/ready handshake and executes each as a short multi-cycle operation. It maintains the Random register and drives the `entries` array consumed by every `tlb_lookup` instance in the MMU. It sits between the CP0 block and the instruction/data address-translation paths.

## Interface
- `N_TLB_ENTRIES`, 32, number of TLB entries; must be a power of two, ≥ 2. `IW` = `$clog2(N_TLB_ENTRIES)`.
- One clock; reset is asynchronous and active-low. Ports `clk` and `rst` (active-low, asynchronous).
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `op_valid` in 1: TLB instruction request.
- `op` in 2 (`tlb_op_t`): instruction to execute; TLBP=0, TLBR=1, TLBWI=2, TLBWR=3.
- `op_ready` out 1: controller can accept an op.
- `done` out 1: one-cycle pulse; results valid.
- `cp0_entryhi`, `cp0_entrylo0`, `cp0_entrylo1`, `cp0_pagemask` in 32 each: CP0 register values, sampled at accept.
- `cp0_index` in IW: target index for TLBWI/TLBR, sampled at accept.
- `cp0_wired` in IW: CP0 Wired value.
- `wired_we` in 1: CP0 is writing Wired this cycle.
- `entries` out `tlb_entry_t [N-1:0]`: current TLB contents.
- `rd_entry` out `tlb_entry_t`: TLBR result.
- `probe_index` out IW: TLBP result index.
- `probe_miss` out 1: TLBP result miss flag.
- `random` out IW: Random register.
- `tlb_update` out 1: one-cycle pulse when entries change; flushes micro-TLBs.

## Operation
- FSM states: IDLE → EXEC → DONE → IDLE. All transitions are unconditional except leaving IDLE.
- IDLE: `op_ready`=1. On `op_valid`:
  - latch `op` and the CP0 inputs;
  - latch the write index: `cp0_index` for TLBWI, current `random` for TLBWR;
  - go to EXEC.
- EXEC: `op_ready`=0. Action by op:
  - TLBP: search with vaddr={entryhi[31:13],13'b0} and asid=entryhi[7:0]. Match rule: `(vpn2 & ~mask)` equal and (G or asid equal). Register `probe_miss` and `probe_index`. On multiple hits, the lowest index wins. On a miss, `probe_index`=0.
  - TLBR: register `rd_entry` = `entries[idx]`.
  - TLBWI/TLBWR: at the EXEC clock edge, write `entries[idx]`:
    - vpn2=entryhi[31:13], asid=entryhi[7:0], mask=pagemask[24:13];
    - pfnX=entryloX[25:6], cX=entryloX[5:3], dX=entryloX[2], vX=entryloX[1];
    - G = entrylo0[0] & entrylo1[0].
- DONE: `done`=1 for exactly one cycle. `tlb_update`=1 in DONE for writes only. Return to IDLE.
- Result outputs (`rd_entry`, `probe_*`) hold their value until overwritten by the next op of the same kind.
- Random register:
  - Updates every cycle: if `random == cp0_wired`, or `random == 0`, load N-1; otherwise decrement.
  - `wired_we` has priority and loads N-1.
  - If Wired ≥ N-1, `random` stays at N-1.
- Simultaneous events:
  - TLBWR accepted in the same cycle as `wired_we`: the write uses the pre-update `random`.
  - A `wired_we` during EXEC does not change the latched index.
- `op_valid` outside IDLE is ignored; the requester holds it until it sees `op_ready`.

## Timing
- Accept at edge t. EXEC occupies cycle t+1. `done` is high in cycle t+2. Next accept is possible at t+3.
- Throughput: one op per 3 cycles.
- A write is visible on `entries` from cycle t+2. `tlb_update` aligns with `done`.
- Reset values:
  - state = IDLE, `op_ready`=1, `done`=0, `tlb_update`=0;
  - `entries` all zero (all invalid, G=0);
  - `rd_entry`=0, `probe_index`=0, `probe_miss`=1, `random`=N-1.
- Reset asserted mid-operation aborts it: no partial write and no `done`.

## Structure
- `mmu.svh` (shared) holds `tlb_entry_t`, `tlb_op_t` and the `TLB_OP_*` constants.
- One sub-module, `tlb_probe`: a combinational matcher returning `{miss, index}` from `entries`, `vpn2` and `asid`. It is instantiated once, and its output is registered in EXEC.
- The random counter lives inline.

## Test plan
- After reset: `random`=31, `entries`=0, `probe_miss`=1, `op_ready`=1. After 5 idle cycles with Wired=0, `random`=26.
- TLBWI with index=5, entryhi=0x0040_2011, lo0=0x0000_1017, lo1=0x0000_1057 → in cycle t+2:
  - `entries[5].vpn2`=0x00201, asid=0x11, G=1, pfn0=0x40;
  - `done` and `tlb_update` each pulse once.
- TLBP after that write, with entryhi=0x0040_2022 → `probe_miss`=0, `probe_index`=5 (G match). With entryhi=0x0080_0022 → `probe_miss`=1.
- Wired=4, Random at 4 → next cycle 31. `wired_we` while `random`=10 → 31. TLBWR accepted in that same cycle writes entry 10.
- Back-to-back `op_valid` held high for 2 ops → accepts spaced 3 cycles apart, `op_ready` low in EXEC/DONE. TLBR of index 5 returns the written entry.
- `rst` asserted during EXEC of a TLBWI → entry unchanged (zero), no `done`, FSM in IDLE.
